regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (Rdst/wdata/writereg) between two writeback requesters.
- Requester A is the ALU writeback: single-cycle, high priority.
- Requester B is the load unit: multi-cycle, buffered in a small FIFO.
- Exports busy flags so decode can stall on registers with writes still in flight.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: ALU writeback (A) has priority over a FIFO of load writebacks (B).
// Latency: 1 cycle select-to-write; backpressure: a_ready/b_ready drop when the B queue is full.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_dst,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_dst,
    input  logic [31:0] b_data,
    output logic [4:0]  Rdst,
    output logic [31:0] wdata,
    output logic        writereg,
    input  logic [4:0]  q_src1,
    input  logic [4:0]  q_src2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic [2:0]  q_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]       dst_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic [4:0]       rdst_q, rdst_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             writereg_q, writereg_d;

    logic             full, sel_a, sel_q, push;
    logic [4:0]       sel_dst;
    logic [31:0]      sel_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full queue blocks A so the head can drain (starvation guard)
    assign full    = (count_q == 3'(DEPTH));
    assign a_ready = !reset && !full;
    assign b_ready = !reset && !full;
    assign sel_a   = a_valid && a_ready;
    assign sel_q   = !reset && !sel_a && (count_q != 3'd0);
    assign push    = b_valid && b_ready;

    assign sel_dst  = sel_a ? a_dst  : dst_mem[head_q];
    assign sel_data = sel_a ? a_data : data_mem[head_q];

    always_comb begin
        vld_d      = vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + {2'b00, push} - {2'b00, sel_q};
        rdst_d     = rdst_q;
        wdata_d    = wdata_q;
        writereg_d = 1'b0;
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
        if (sel_q) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (sel_a || sel_q) begin
            rdst_d     = sel_dst;
            wdata_d    = sel_data;
            writereg_d = !(R0_HARDWIRED && (sel_dst == 5'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 3'd0;
            rdst_q     <= 5'd0;
            wdata_q    <= 32'd0;
            writereg_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rdst_q     <= rdst_d;
            wdata_q    <= wdata_d;
            writereg_q <= writereg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dst_mem[tail_q]  <= b_dst;
            data_mem[tail_q] <= b_data;
        end
    end

    // An unaccepted incoming B request is deliberately not visible here
    always_comb begin
        q_busy1 = writereg_q && (rdst_q == q_src1);
        q_busy2 = writereg_q && (rdst_q == q_src2);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (dst_mem[i] == q_src1)) q_busy1 = 1'b1;
            if (vld_q[i] && (dst_mem[i] == q_src2)) q_busy2 = 1'b1;
        end
        if (R0_HARDWIRED && (q_src1 == 5'd0)) q_busy1 = 1'b0;
        if (R0_HARDWIRED && (q_src2 == 5'd0)) q_busy2 = 1'b0;
    end

    assign Rdst     = rdst_q;
    assign wdata    = wdata_q;
    assign writereg = writereg_q;
    assign q_count  = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; a second instance runs with register 0 hardwired.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_dst, b_dst, q_src1, q_src2;
    logic [31:0] a_data, b_data;

    logic        a_ready, b_ready, writereg, q_busy1, q_busy2;
    logic [4:0]  Rdst;
    logic [31:0] wdata;
    logic [2:0]  q_count;

    logic        z_a_ready, z_b_ready, z_writereg, z_busy1, z_busy2;
    logic [4:0]  z_Rdst;
    logic [31:0] z_wdata;
    logic [2:0]  z_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2), .R0_HARDWIRED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
        .Rdst(Rdst), .wdata(wdata), .writereg(writereg),
        .q_src1(q_src1), .q_src2(q_src2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .q_count(q_count)
    );

    regfile_wb_arbiter #(.DEPTH(2), .R0_HARDWIRED(1'b1)) dut_r0 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(z_a_ready), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(z_b_ready), .b_dst(b_dst), .b_data(b_data),
        .Rdst(z_Rdst), .wdata(z_wdata), .writereg(z_writereg),
        .q_src1(q_src1), .q_src2(q_src2), .q_busy1(z_busy1), .q_busy2(z_busy2),
        .q_count(z_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven 1ns after it and checked 2ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_dst = '0; a_data = '0; b_dst = '0; b_data = '0;
        q_src1 = 5'd31; q_src2 = 5'd30;
        tick(); tick(); #1;
        check("rst_count", 32'(q_count), 0);
        check("rst_wr", 32'(writereg), 0);
        check("rst_rdst", 32'(Rdst), 0);
        check("rst_wdata", wdata, 0);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);

        // A only
        reset = 1'b0; a_valid = 1'b1; a_dst = 5'd5; a_data = 32'hDEADBEEF;
        #1 check("aonly_ready", 32'(a_ready), 1);
        tick(); a_valid = 1'b0;
        #1 check("aonly_wr", 32'(writereg), 1);
        check("aonly_rdst", 32'(Rdst), 5);
        check("aonly_wdata", wdata, 32'hDEADBEEF);
        tick(); #1;
        check("aonly_idle_wr", 32'(writereg), 0);
        check("aonly_idle_rdst", 32'(Rdst), 5);

        // A and B together with an empty queue
        a_valid = 1'b1; a_dst = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_dst = 5'd7; b_data = 32'h22;
        #1 check("ab_a_ready", 32'(a_ready), 1);
        check("ab_b_ready", 32'(b_ready), 1);
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        #1 check("ab_c1_rdst", 32'(Rdst), 3);
        check("ab_c1_wdata", wdata, 32'h11);
        check("ab_c1_wr", 32'(writereg), 1);
        check("ab_c1_count", 32'(q_count), 1);
        tick(); #1;
        check("ab_c2_rdst", 32'(Rdst), 7);
        check("ab_c2_wdata", wdata, 32'h22);
        check("ab_c2_wr", 32'(writereg), 1);
        check("ab_c2_count", 32'(q_count), 0);

        // Starvation guard: A held continuously, two B pushes fill the queue
        a_valid = 1'b1; a_dst = 5'd20; a_data = 32'hA0;
        b_valid = 1'b1; b_dst = 5'd1; b_data = 32'hB1;
        tick(); b_dst = 5'd2; b_data = 32'hB2;
        #1 check("sg_rdst_a1", 32'(Rdst), 20);
        check("sg_count1", 32'(q_count), 1);
        check("sg_b_ready1", 32'(b_ready), 1);
        tick(); b_valid = 1'b0;
        #1 check("sg_count2", 32'(q_count), 2);
        check("sg_full_a_ready", 32'(a_ready), 0);
        check("sg_full_b_ready", 32'(b_ready), 0);
        tick(); #1;
        check("sg_drain_rdst", 32'(Rdst), 1);
        check("sg_drain_wdata", wdata, 32'hB1);
        check("sg_drain_count", 32'(q_count), 1);
        check("sg_a_ready_back", 32'(a_ready), 1);
        tick(); a_valid = 1'b0;
        #1 check("sg_a_again", 32'(Rdst), 20);
        check("sg_a_again_cnt", 32'(q_count), 1);
        tick(); #1;
        check("sg_last_rdst", 32'(Rdst), 2);
        check("sg_last_wdata", wdata, 32'hB2);
        check("sg_last_count", 32'(q_count), 0);
        tick();

        // Busy lookup with A continuously active
        q_src1 = 5'd9; q_src2 = 5'd10;
        a_valid = 1'b1; a_dst = 5'd11; a_data = 32'hAB;
        b_valid = 1'b1; b_dst = 5'd9; b_data = 32'h99;
        #1 check("busy_incoming", 32'(q_busy1), 0);
        tick(); b_valid = 1'b0;
        #1 check("busy_q1", 32'(q_busy1), 1);
        check("busy_q2", 32'(q_busy2), 0);
        tick(); a_valid = 1'b0;
        #1 check("busy_q1_held", 32'(q_busy1), 1);
        tick(); #1;
        check("busy_out_rdst", 32'(Rdst), 9);
        check("busy_out_stage", 32'(q_busy1), 1);
        tick(); #1;
        check("busy_cleared", 32'(q_busy1), 0);

        // Register-0 writes: hardwired instance completes the handshake but never writes
        q_src1 = 5'd0;
        a_valid = 1'b1; a_dst = 5'd0; a_data = 32'hFFFFFFFF;
        #1 check("r0_a_ready", 32'(z_a_ready), 1);
        tick(); a_valid = 1'b0;
        #1 check("r0_wr", 32'(z_writereg), 0);
        check("r0_busy", 32'(z_busy1), 0);
        check("r0_plain_wr", 32'(writereg), 1);
        check("r0_plain_busy", 32'(q_busy1), 1);
        tick();

        // Reset mid-stream with a full queue and a live write
        a_valid = 1'b1; a_dst = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_dst = 5'd12; b_data = 32'hC1;
        tick(); tick(); b_valid = 1'b0;
        #1 check("mid_count_pre", 32'(q_count), 2);
        check("mid_wr_pre", 32'(writereg), 1);
        reset = 1'b1;
        #1 check("mid_a_ready", 32'(a_ready), 0);
        check("mid_b_ready", 32'(b_ready), 0);
        tick(); #1;
        check("mid_count", 32'(q_count), 0);
        check("mid_wr", 32'(writereg), 0);
        check("mid_rdst", 32'(Rdst), 0);
        check("mid_wdata", wdata, 0);
        reset = 1'b0; a_valid = 1'b0;
        tick(); #1;
        check("post_rst_idle", 32'(writereg), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
